// File: rtl/seq_div_if.sv
// Request/result bundle for the sequential divider: operands and start in, status and results out.
interface seq_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div.sv
// Restoring shift-subtract divider, one quotient bit per clock, WIDTH+3 cycle back-to-back period.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncation toward zero); default is unsigned.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    seq_div_if.slave   bus
);
`ifdef SEQ_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return neg_if(v, SIGNED_EN && v[WIDTH-1]);
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  quo_w_q;
    logic [WIDTH-1:0]  rem_w_q;
    logic [WIDTH-1:0]  dvs_q;
    logic              a_neg_q, b_neg_q;
    logic [WIDTH-1:0]  quotient_q, remainder_q;
    logic              dbz_q;

    logic              accept;
    logic              dvs_zero;
    logic [WIDTH:0]    rem_sh;
    logic              ge;
    logic [WIDTH-1:0]  rem_nx, quo_nx;

    assign accept   = (state_q == IDLE) && bus.start;
    assign dvs_zero = (dvs_q == '0);

    // Partial remainder carries one extra bit so the shifted value never loses its MSB before the compare.
    assign rem_sh = {rem_w_q, quo_w_q[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, dvs_q};
    assign rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo_w_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                if (dvs_zero) begin
                    state_d = DONE;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                dbz_q <= 1'b0;
            end
            if (state_q == CALC && dvs_zero) begin
                quotient_q  <= '1;
                remainder_q <= neg_if(quo_w_q, a_neg_q);
                dbz_q       <= 1'b1;
            end
            // Sign correction: quotient follows sign mismatch, remainder follows the dividend.
            if (state_q == FIX) begin
                quotient_q  <= neg_if(quo_w_q, a_neg_q ^ b_neg_q);
                remainder_q <= neg_if(rem_w_q, a_neg_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            quo_w_q <= magnitude(bus.dividend);
            rem_w_q <= '0;
            dvs_q   <= magnitude(bus.divisor);
            a_neg_q <= SIGNED_EN && bus.dividend[WIDTH-1];
            b_neg_q <= SIGNED_EN && bus.divisor[WIDTH-1];
        end else if (state_q == CALC) begin
            quo_w_q <= quo_nx;
            rem_w_q <= rem_nx;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: stimulus pushes expected results, a negedge monitor checks them.
module tb_seq_div;
    localparam int W = 32;

    typedef struct {
        int          exp_edge;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic clock;
    logic reset;
    seq_div_if #(.WIDTH(W)) bus ();

    seq_div #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          edge_cnt = 0;
    int          acc_edge = -1000;
    int          lat_cur  = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic [31:0] last_q   = '0;
    logic [31:0] last_r   = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Reference: plain division from the arithmetic definition, no knowledge of the iteration.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        int sa, sb_v;
        z = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa   = a;
                sb_v = b;
                q = 32'(sa / sb_v);
                r = 32'(sa % sb_v);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: the only process that compares DUT outputs.
    always @(negedge clock) begin
        if (reset) begin
            chk(bus.busy == 1'b0, "reset_busy", 32'(bus.busy), 32'd0);
            chk(bus.done == 1'b0, "reset_done", 32'(bus.done), 32'd0);
            chk(bus.quotient == 32'd0, "reset_quotient", bus.quotient, 32'd0);
            chk(bus.remainder == 32'd0, "reset_remainder", bus.remainder, 32'd0);
            chk(bus.div_by_zero == 1'b0, "reset_dbz", 32'(bus.div_by_zero), 32'd0);
            last_q = '0;
            last_r = '0;
        end else begin
            logic exp_busy;
            exp_busy = (acc_edge >= 0) && (edge_cnt >= acc_edge) && (edge_cnt <= acc_edge + lat_cur);
            chk(bus.busy == exp_busy, "busy", 32'(bus.busy), 32'(exp_busy));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(edge_cnt == e.exp_edge, "done_edge", 32'(edge_cnt), 32'(e.exp_edge));
                    chk(bus.quotient == e.q, "quotient", bus.quotient, e.q);
                    chk(bus.remainder == e.r, "remainder", bus.remainder, e.r);
                    chk(bus.div_by_zero == e.z, "div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
                    last_q = e.q;
                    last_r = e.r;
                end
            end else begin
                chk(bus.quotient == last_q, "quotient_hold", bus.quotient, last_q);
                chk(bus.remainder == last_r, "remainder_hold", bus.remainder, last_r);
                if (sb.size() > 0 && edge_cnt > sb[0].exp_edge) begin
                    chk(1'b0, "missing_done", 32'(edge_cnt), 32'(sb[0].exp_edge));
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Called at a negedge while the DUT is idle; returns one negedge later with start released.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic z, input bit track);
        exp_t e;
        acc_edge = edge_cnt + 1;
        lat_cur  = (b == 32'd0) ? 1 : W + 1;
        if (track) begin
            e.exp_edge = acc_edge + lat_cur;
            e.q = q;
            e.r = r;
            e.z = z;
            sb.push_back(e);
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        logic        z;
        model(a, b, q, r, z);
        issue(a, b, q, r, z, 1'b1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (bus.done) break;
            @(negedge clock);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        wait_done();
        @(negedge clock);

        issue(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1);
        wait_done();
        @(negedge clock);

        // A second start mid-operation must be ignored entirely.
        issue(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 1'b1);
        repeat (4) @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = 32'd81;
        bus.divisor  = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done();
        repeat (40) @(negedge clock);

        // Reset mid-operation: asserted away from any clock edge, then a fresh divide on the first edge after release.
        issue(32'd999, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clock);
        @(posedge clock);
        #1;
        reset    = 1'b1;
        acc_edge = -1000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
        wait_done();
        @(negedge clock);

`ifdef SEQ_DIV_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done();
        @(negedge clock);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        wait_done();
        @(negedge clock);
`else
        issue(32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b1);
        wait_done();
        @(negedge clock);
`endif

        // Back-to-back: each start lands in the idle cycle right after done.
        for (int k = 0; k < 3; k++) begin
            issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
            wait_done();
            @(negedge clock);
        end

        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2, 3: b = 32'($urandom_range(1, 15));
                4, 5:    b = $urandom;
                default: b = a >> $urandom_range(0, 31);
            endcase
            issue_model(a, b);
            wait_done();
            repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
